// File: rtl/rf_ctrl_pkg.sv
// Shared constants and the write-record type for the register-file write-port controller.
package rf_ctrl_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    // One pending register-file write: destination plus data.
    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } rf_wr_t;

    // x0 is hard-wired to zero, so it is never a real destination or hazard source.
    function automatic logic is_x0(input logic [AW-1:0] r);
        return (r == '0);
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Two-entry synchronous FIFO buffering multicycle results until they win the write port.
// Push is ignored when full and pop is ignored when empty; the output is the current head.
module rf_wb_fifo
    import rf_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  rf_wr_t din,
    input  logic   pop,
    output rf_wr_t dout,
    output logic   empty,
    output logic   full
);

    rf_wr_t     mem_q [2];
    rf_wr_t     mem_d [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push;
    logic       do_pop;

    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);
    assign dout  = mem_q[rd_ptr_q];

    // Next-state: write at the tail, advance pointers, track occupancy.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    // State registers; reset discards any buffered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter.
// Pipeline writeback always wins the port; multicycle results queue in a 2-entry FIFO and
// drain whenever writeback is idle. A busy scoreboard tracks outstanding multicycle
// destinations for decode hazard detection, and a starvation counter asks the pipeline for
// a bubble when the FIFO head keeps losing.
// Handshake: a multicycle result transfers on a rising edge where mc_valid && mc_ready;
// mc_ready depends only on FIFO occupancy (and reset), never on mc_valid.
module regfile_wb_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              mc_valid,
    output logic              mc_ready,
    input  logic [AW-1:0]     mc_rd,
    input  logic [XLEN-1:0]   mc_data,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    input  logic [AW-1:0]     chk_rs1,
    input  logic [AW-1:0]     chk_rs2,
    input  logic [AW-1:0]     chk_rd,
    output logic              hazard_stall,
    output logic              starve_o,
    output logic [NREG-1:0]   busy_o,
    output logic              rf_we,
    output logic [AW-1:0]     rf_a3,
    output logic [XLEN-1:0]   rf_wd
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    rf_wr_t          fifo_din;
    rf_wr_t          fifo_head;
    logic            fifo_empty;
    logic            fifo_full;
    logic            fifo_push;
    logic            fifo_pop;
    logic            wb_win;

    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            starve_q, starve_d;

    assign fifo_din.rd   = mc_rd;
    assign fifo_din.data = mc_data;

    // Accept results only when there is room; never while reset is held.
    assign mc_ready  = !rst && !fifo_full;
    assign fifo_push = mc_valid && mc_ready;

    // Writeback to x0 is treated as no writeback at all.
    assign wb_win   = wb_we && !is_x0(wb_rd);
    assign fifo_pop = !rst && !wb_win && !fifo_empty;

    rf_wb_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Write-port mux: writeback first, then FIFO head, else drive zeros.
    always_comb begin
        rf_we = 1'b0;
        rf_a3 = '0;
        rf_wd = '0;
        if (!rst) begin
            if (wb_win) begin
                rf_we = 1'b1;
                rf_a3 = wb_rd;
                rf_wd = wb_data;
            end else if (fifo_pop) begin
                rf_we = !is_x0(fifo_head.rd);
                rf_a3 = fifo_head.rd;
                rf_wd = fifo_head.data;
            end
        end
    end

    // Scoreboard next-state: clear on pop, set on issue; set is applied last so it wins.
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop && !is_x0(fifo_head.rd)) begin
            busy_d[fifo_head.rd] = 1'b0;
        end
        if (issue_valid && !is_x0(issue_rd)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Starvation next-state: count lost arbitration rounds of a waiting head, saturating.
    always_comb begin
        cnt_d    = cnt_q;
        starve_d = starve_q;
        if (fifo_empty || fifo_pop) begin
            cnt_d = '0;
        end else if (wb_win && (cnt_q != CW'(STARVE_LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (fifo_pop) begin
            starve_d = 1'b0;
        end else if (cnt_d == CW'(STARVE_LIMIT)) begin
            starve_d = 1'b1;
        end
    end

    // Scoreboard and starvation registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            cnt_q    <= '0;
            starve_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    // Decode hazard: any non-x0 operand or destination with an outstanding multicycle write.
    always_comb begin
        hazard_stall = 1'b0;
        if (!is_x0(chk_rs1) && busy_q[chk_rs1]) hazard_stall = 1'b1;
        if (!is_x0(chk_rs2) && busy_q[chk_rs2]) hazard_stall = 1'b1;
        if (!is_x0(chk_rd)  && busy_q[chk_rd])  hazard_stall = 1'b1;
    end

    assign busy_o   = busy_q;
    assign starve_o = starve_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Controls the register file's single write port (we3/a3/wd3). Two sources share it:
- Pipeline writeback: fixed priority, cannot be back-pressured.
- Multicycle unit (mul/div, late loads): valid/ready handshake, buffered in a 2-entry FIFO.

The block also keeps a per-register busy scoreboard for outstanding multicycle destinations, and produces hazard stall and starvation bubble requests for the pipeline controller.

Parameters:
XLEN, 32, data width of a register write
AW, 5, register address width
NREG, 32, number of architectural registers (2**AW)
STARVE_LIMIT, 4, consecutive cycles a pending FIFO head may lose arbitration before starve_o asserts

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
wb_we  in  1  pipeline writeback enable
wb_rd  in  AW  pipeline writeback destination
wb_data  in  XLEN  pipeline writeback data
mc_valid  in  1  multicycle result valid
mc_ready  out  1  FIFO can accept a result
mc_rd  in  AW  multicycle result destination
mc_data  in  XLEN  multicycle result data
issue_valid  in  1  a multicycle op is dispatched this cycle
issue_rd  in  AW  destination of the dispatched op
chk_rs1  in  AW  decode-stage source 1
chk_rs2  in  AW  decode-stage source 2
chk_rd  in  AW  decode-stage destination
hazard_stall  out  1  decode operand/destination is busy
starve_o  out  1  request one pipeline bubble so the FIFO can drain
busy_o  out  NREG  scoreboard bits
rf_we  out  1  to register file we3
rf_a3  out  AW  to register file a3
rf_wd  out  XLEN  to register file wd3

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - FIFO empty; busy_o = 0; starvation counter = 0; starve_o = 0.
  - While rst = 1: rf_we = 0 and mc_ready = 0.
- Register x0:
  - x0 is never busy; issue_rd = 0 is ignored.
  - Writeback with wb_rd = 0 counts as idle.
  - A FIFO head with rd = 0 pops with rf_we = 0.
- Write-port arbitration (combinational each cycle):
  - If wb_we && wb_rd != 0: rf_we = 1, rf_a3 = wb_rd, rf_wd = wb_data. The FIFO holds.
  - Else if FIFO not empty: pop the head. rf_we = (head.rd != 0), rf_a3 = head.rd, rf_wd = head.data.
  - Else: rf_we = 0; rf_a3 and rf_wd are 0.
- FIFO:
  - Depth 2; mc_ready = !full.
  - Push on mc_valid && mc_ready.
  - No bypass: a result accepted in cycle N is written to the register file no earlier than cycle N+1.
  - Simultaneous push and pop allowed when count is 1. When full, mc_ready stays 0 even if a pop occurs that cycle.
  - Ordering is strictly FIFO.
- Scoreboard:
  - issue_valid && issue_rd != 0 sets busy[issue_rd] at the next edge.
  - A FIFO pop with rd != 0 clears busy[rd] at the same edge.
  - Set and clear of the same register in the same cycle: set wins.
  - Issuing to an already-busy register is illegal (prevented by hazard_stall); the bit remains set.
- hazard_stall (combinational) = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd], with x0 terms forced to 0. No forwarding from the FIFO.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and writeback wins.
  - It clears on any pop, or when the FIFO is empty.
  - starve_o is registered: it goes 1 at the edge where the counter reaches STARVE_LIMIT, and stays 1 until the edge of the next pop.
  - The arbiter never drops a writeback, even while starve_o = 1.
- Reset mid-operation: FIFO contents and busy bits are discarded. No register-file write occurs during the reset cycle.

Decomposition:
- Package rf_ctrl_pkg contains:
  - Constants XLEN, AW, NREG.
  - Typedef rf_wr_t (packed: rd[AW], data[XLEN]).
- Sub-module rf_wb_fifo: 2-entry synchronous FIFO of rf_wr_t.
  - Ports: clk, rst, push, din, pop, dout, empty, full.
- Scoreboard and starvation counter live in the top module.

Test Plan:
1. Reset, then wb_we=1, wb_rd=5, wb_data=32'h6969 for one cycle -> same cycle rf_we=1, rf_a3=5, rf_wd=32'h6969; busy_o=0.
2. issue_valid, issue_rd=7 -> busy_o[7]=1 next cycle; chk_rs2=7 gives hazard_stall=1. Then mc result rd=7, data=32'hCAFE with wb idle -> written one cycle after acceptance; busy_o[7]=0 after that edge; hazard_stall=0.
3. Two mc results (rd=3/32'h1, rd=4/32'h2) while wb_we=1 continuously -> mc_ready=0 after the second push; starve_o=1 after 4 blocked cycles. Then drop wb_we -> writes rd=3 then rd=4 in order; starve_o returns to 0 after the first pop.
4. Same cycle: issue_rd=9 and pop of a FIFO head with rd=9 -> rf_we=1 to x9 and busy_o[9] stays 1.
5. mc result rd=0, data=32'hFFFF; issue_rd=0 -> rf_we stays 0 on pop; busy_o[0] is never set; hazard_stall=0 for chk_rs1=0.
6. rst asserted with FIFO holding 2 entries and busy_o[3]=1 -> next cycle FIFO empty, busy_o=0, starve_o=0; no register-file write during or after reset.
